// File: rtl/apb_bridge_pkg.sv
// Shared types and helpers for apb_regfile_bridge: FSM state encoding, alignment mask
// and the byte-lane merge used by read-modify-write (APB_BRIDGE_PSTRB_EN builds only).
package apb_bridge_pkg;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
`ifdef APB_BRIDGE_PSTRB_EN
        RMW_RD = 3'd2,
        RMW_WR = 3'd3,
`endif
        WAIT   = 3'd4,
        RESP   = 3'd5
    } state_e;

    // Bytes with a set strobe come from the new write data, the rest from the captured read.
    function automatic logic [31:0] merge_bytes(input logic [31:0] wdata,
                                                input logic [31:0] rdata,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = rdata;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                merged[i*8 +: 8] = wdata[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/apb_regfile_bridge.sv
// APB3/APB4 slave that turns each transfer into one registered strobe on the regfile bus.
// Define APB_BRIDGE_PSTRB_EN to honour pstrb via read-modify-write; otherwise writes are full-word.
module apb_regfile_bridge
    import apb_bridge_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    WAIT_STATES = 0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_MAX    = 'h1C
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [3:0]            pstrb,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  chip_select,
    output logic                  write_en,
    output logic                  read_en,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic                  data_valid
);

    // Transfers that skip the strobe cycle spend one extra cycle in WAIT to keep latency equal.
    localparam logic [4:0] WAIT_LOAD      = 5'(WAIT_STATES);
    localparam logic [4:0] WAIT_LOAD_SKIP = 5'(WAIT_STATES + 1);

    state_e                  state_q, state_d;
    logic [4:0]              cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic [ADDR_WIDTH-1:0]   lat_addr_q, lat_addr_d;
    logic                    lat_write_q, lat_write_d;
    logic [DATA_WIDTH-1:0]   lat_wdata_q, lat_wdata_d;
    logic                    addr_err;

    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    chip_select_q, chip_select_d;
    logic                    write_en_q, write_en_d;
    logic                    read_en_q, read_en_d;
    logic [DATA_WIDTH-1:0]   write_data_q, write_data_d;

`ifdef APB_BRIDGE_PSTRB_EN
    logic [3:0]              lat_strb_q, lat_strb_d;
    logic [DATA_WIDTH-1:0]   rmw_data_q, rmw_data_d;
`else
    logic                    unused_pstrb;
    assign unused_pstrb = ^pstrb;
`endif

    assign addr_err = ((paddr[1:0] & ALIGN_MASK) != 2'b00) || (paddr > ADDR_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            lat_addr_q    <= '0;
            lat_write_q   <= 1'b0;
            lat_wdata_q   <= '0;
            prdata_q      <= '0;
            pready_q      <= 1'b0;
            pslverr_q     <= 1'b0;
            addr_q        <= '0;
            chip_select_q <= 1'b0;
            write_en_q    <= 1'b0;
            read_en_q     <= 1'b0;
            write_data_q  <= '0;
`ifdef APB_BRIDGE_PSTRB_EN
            lat_strb_q    <= '0;
            rmw_data_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            lat_addr_q    <= lat_addr_d;
            lat_write_q   <= lat_write_d;
            lat_wdata_q   <= lat_wdata_d;
            prdata_q      <= prdata_d;
            pready_q      <= pready_d;
            pslverr_q     <= pslverr_d;
            addr_q        <= addr_d;
            chip_select_q <= chip_select_d;
            write_en_q    <= write_en_d;
            read_en_q     <= read_en_d;
            write_data_q  <= write_data_d;
`ifdef APB_BRIDGE_PSTRB_EN
            lat_strb_q    <= lat_strb_d;
            rmw_data_q    <= rmw_data_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        lat_addr_d  = lat_addr_q;
        lat_write_d = lat_write_q;
        lat_wdata_d = lat_wdata_q;
`ifdef APB_BRIDGE_PSTRB_EN
        lat_strb_d  = lat_strb_q;
        rmw_data_d  = rmw_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    lat_addr_d  = paddr;
                    lat_write_d = pwrite;
                    lat_wdata_d = pwdata;
                    err_d       = addr_err;
`ifdef APB_BRIDGE_PSTRB_EN
                    lat_strb_d  = pstrb;
`endif
                    if (addr_err) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD_SKIP;
`ifdef APB_BRIDGE_PSTRB_EN
                    end else if (pwrite && pstrb == 4'h0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD_SKIP;
                    end else if (pwrite && pstrb != 4'hF) begin
                        state_d = RMW_RD;
`endif
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (!lat_write_q && !data_valid) begin
                    err_d = 1'b1;
                end
                if (WAIT_STATES > 0) begin
                    state_d = WAIT;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    state_d = RESP;
                end
            end
`ifdef APB_BRIDGE_PSTRB_EN
            RMW_RD: begin
                if (data_valid) begin
                    rmw_data_d = read_data;
                    state_d    = RMW_WR;
                end else begin
                    err_d   = 1'b1;
                    state_d = WAIT;
                    cnt_d   = WAIT_LOAD_SKIP;
                end
            end
            RMW_WR: begin
                if (WAIT_STATES > 0) begin
                    state_d = WAIT;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    state_d = RESP;
                end
            end
`endif
            WAIT: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q <= 5'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so each strobe lands in the cycle it belongs to.
    always_comb begin
        chip_select_d = 1'b0;
        write_en_d    = 1'b0;
        read_en_d     = 1'b0;
        pready_d      = 1'b0;
        pslverr_d     = 1'b0;
        addr_d        = addr_q;
        write_data_d  = write_data_q;
        prdata_d      = prdata_q;
        case (state_d)
            ISSUE: begin
                chip_select_d = 1'b1;
                write_en_d    = lat_write_d;
                read_en_d     = !lat_write_d;
                addr_d        = lat_addr_d;
                write_data_d  = lat_wdata_d;
            end
`ifdef APB_BRIDGE_PSTRB_EN
            RMW_RD: begin
                chip_select_d = 1'b1;
                read_en_d     = 1'b1;
                addr_d        = lat_addr_d;
            end
            RMW_WR: begin
                chip_select_d = 1'b1;
                write_en_d    = 1'b1;
                addr_d        = lat_addr_d;
                write_data_d  = merge_bytes(lat_wdata_d, rmw_data_d, lat_strb_d);
            end
`endif
            RESP: begin
                pready_d  = 1'b1;
                pslverr_d = err_d;
            end
            default: begin
            end
        endcase
        if (state_q == ISSUE && !lat_write_q) begin
            prdata_d = data_valid ? read_data : '0;
        end else if (state_q == IDLE && state_d == WAIT && err_d && !lat_write_d) begin
            prdata_d = '0;
        end
    end

    assign prdata      = prdata_q;
    assign pready      = pready_q;
    assign pslverr     = pslverr_q;
    assign addr        = addr_q;
    assign chip_select = chip_select_q;
    assign write_en    = write_en_q;
    assign read_en     = read_en_q;
    assign write_data  = write_data_q;

endmodule

// File: doc/apb_regfile_bridge.md
# apb_regfile_bridge

APB slave front-end for the generated register files. It accepts APB3/APB4 transfers from the peripheral interconnect and converts each one into a single-cycle chip_select/write_en/read_en strobe on the register file's native bus. It captures read_data, inserts configurable wait states, and returns PREADY/PSLVERR. It sits directly upstream of every generated regfile instance, one bridge per regfile.

## Interface
Parameters:
- ADDR_WIDTH, 8, byte-address width shared with the regfile addr port
- DATA_WIDTH, 32, data width; must be 32
- WAIT_STATES, 0, extra access cycles inserted before PREADY (0..15)
- ADDR_MAX, 8'h1C, highest mapped word address; anything above it errors

Ports:
- clk  in  1  single clock, all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- psel  in  1  APB select
- penable  in  1  APB enable, marks the access phase
- pwrite  in  1  1 = write, 0 = read
- paddr  in  ADDR_WIDTH  APB byte address
- pwdata  in  32  APB write data
- pstrb  in  4  APB4 byte strobes
- prdata  out  32  read data, valid while pready=1
- pready  out  1  transfer complete
- pslverr  out  1  error response, valid while pready=1
- addr  out  ADDR_WIDTH  regfile address
- chip_select  out  1  regfile select strobe
- write_en  out  1  regfile write strobe
- read_en  out  1  regfile read strobe
- write_data  out  32  regfile write data
- read_data  in  32  regfile combinational read data
- data_valid  in  1  regfile read-active indication

## Operation
- All outputs are registered. Reset value of every output is 0.
- FSM states:
  - IDLE
  - ISSUE: read or write strobe
  - RMW_RD: only with the macro
  - RMW_WR: only with the macro
  - WAIT
  - RESP
- IDLE:
  - On psel=1, penable=0 (setup), latch paddr, pwrite, pwdata and pstrb.
  - Evaluate the error condition: paddr[1:0]≠0 or paddr>ADDR_MAX.
  - Error → WAIT. No regfile strobe is ever issued on error.
  - Otherwise → ISSUE.
- ISSUE:
  - Assert chip_select=1 and exactly one of write_en/read_en for exactly one cycle, with addr and write_data.
  - Read: prdata is loaded from read_data at the end of the cycle if data_valid=1.
  - Read with data_valid=0: flag an error and set prdata=0.
  - Exit → WAIT if WAIT_STATES>0, else → RESP.
- WAIT: down-counter loaded with WAIT_STATES, exits to RESP at 0.
- RESP: pready=1 for one cycle; pslverr is set if an error was flagged; → IDLE.
- Error reads return prdata=0. prdata otherwise holds the last successful read value.
- Protocol violation (psel dropped before pready): the bridge finishes its internal sequence and returns to IDLE. It never issues a second strobe for the same transfer.

## Timing
- Setup cycle T0 is sampled at the T0 edge.
- Strobes are active in T1.
- pready rises in cycle T(2+WAIT_STATES), which is the 2nd+WAIT_STATES access cycle.
- Error transfers have the same latency as good transfers.
- RMW write (macro on) adds exactly 1 cycle.
- Back-to-back transfers: a setup presented in the cycle after pready is accepted. Minimum throughput is one transfer per 3+WAIT_STATES cycles.
- Reset asserted mid-transfer:
  - Strobes and pready drop asynchronously.
  - The FSM returns to IDLE and the counter clears.
  - No pending write completes.

## Configuration
- APB_BRIDGE_PSTRB_EN defined:
  - pstrb=4'hF: normal write.
  - pstrb=4'h0: no strobe issued, normal pready, pslverr=0.
  - Otherwise, read-modify-write:
    - RMW_RD: issue a read strobe and capture read_data.
    - RMW_WR (next cycle): write the merged data. Each byte comes from pwdata where pstrb=1, else from the captured read value.
  - RMW on side-effect registers (W1C/W1S/pulse) is a software responsibility.
- APB_BRIDGE_PSTRB_EN undefined: pstrb is ignored, every write is a full-word write, and RMW states are not compiled.

## Structure
- Shared package apb_bridge_pkg holds:
  - the state enum
  - ALIGN_MASK=2'b11
  - the byte-merge function
- No sub-module is needed; the counter and FSM live in the single module.

## Test plan
- Read, paddr=8'h04, read_data=32'h0000_0003, WAIT_STATES=0 → read_en high in T1 only; pready in T2; prdata=32'h3; pslverr=0.
- Write, paddr=8'h14, pwdata=32'h0000_AA55 → one-cycle write_en, write_data=32'hAA55, pready in T2.
- Bad addresses: paddr=8'h06 (misaligned) and paddr=8'h20 (above ADDR_MAX) → no chip_select; pready in T2; pslverr=1; prdata=0.
- WAIT_STATES=3 → pready exactly in T5; strobe still one cycle in T1.
- Macro on, pstrb=4'b0010, pwdata=32'h0000_BB00, regfile holds 32'h0000_AA55 → read then write of 32'h0000_BB55; pready in T3.
- Reset asserted in T1 of a write → write_en falls immediately; the register is unchanged; the next transfer after reset completes normally.
